// File: rtl/min_max_tracker.sv
// Streaming min/max tracker: consumes a valid/ready sample stream, tracks the
// running minimum and maximum of each frame with the index of their first
// occurrence, and emits one result beat per frame on a valid/ready output.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   ACCUM | accepting samples; results registers hold the running frame
//   HOLD  | frame closed; result beat presented until out_ready handshake
module min_max_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int IDXW      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
    parameter int CNTW      = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [IDXW-1:0]  out_min_idx,
    output logic [IDXW-1:0]  out_max_idx,
    output logic [CNTW-1:0]  out_count,
    output logic             out_flat
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  min_q, min_d;
    logic [WIDTH-1:0]  max_q, max_d;
    logic [IDXW-1:0]   min_idx_q, min_idx_d;
    logic [IDXW-1:0]   max_idx_q, max_idx_d;
    logic              signed_q, signed_d;

    logic              accept;
    logic              first;
    logic              mode;
    logic              frame_end;
    logic              lt_min;
    logic              gt_max;
    logic [WIDTH:0]    data_ext;
    logic [WIDTH:0]    min_ext;
    logic [WIDTH:0]    max_ext;

    // Handshake qualifiers and signed/unsigned comparison against the running results
    always_comb begin
        in_ready  = (state_q == ACCUM) & ~rst;
        out_valid = (state_q == HOLD) & ~rst;
        accept    = in_valid & in_ready;
        first     = (count_q == '0);
        // First sample of a frame uses the live mode bit; it is latched for the rest.
        mode      = first ? is_signed : signed_q;
        // One extra bit: MSB-extended in signed mode, zero-extended otherwise.
        data_ext  = {mode & in_data[WIDTH-1], in_data};
        min_ext   = {mode & min_q[WIDTH-1], min_q};
        max_ext   = {mode & max_q[WIDTH-1], max_q};
        lt_min    = $signed(data_ext) < $signed(min_ext);
        gt_max    = $signed(data_ext) > $signed(max_ext);
        frame_end = accept & (in_last | (count_q == CNTW'(FRAME_LEN - 1)));
    end

    // Next-state logic for the frame FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (frame_end) state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Next-value logic for the result registers; only accepts update them
    always_comb begin
        count_d   = count_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        signed_d  = signed_q;
        if (accept) begin
            if (first) begin
                min_d     = in_data;
                max_d     = in_data;
                min_idx_d = '0;
                max_idx_d = '0;
                signed_d  = is_signed;
                count_d   = CNTW'(1);
            end else begin
                // Strict compares keep the earliest index on ties.
                if (lt_min) begin
                    min_d     = in_data;
                    min_idx_d = IDXW'(count_q);
                end
                if (gt_max) begin
                    max_d     = in_data;
                    max_idx_d = IDXW'(count_q);
                end
                count_d = count_q + CNTW'(1);
            end
        end
        if ((state_q == HOLD) && out_ready) begin
            count_d = '0;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            count_q   <= '0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            signed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            signed_q  <= signed_d;
        end
    end

    // Result outputs come straight from the registers
    always_comb begin
        out_min     = min_q;
        out_max     = max_q;
        out_min_idx = min_idx_q;
        out_max_idx = max_idx_q;
        out_count   = count_q;
        out_flat    = (min_q == max_q);
    end

endmodule

// File: doc/min_max_tracker.md
# min_max_tracker

Streaming, parametrised successor to the 4-bit magnitude comparator. The block consumes a valid/ready stream of WIDTH-bit samples and tracks the running minimum and maximum over a frame, along with the index where each first occurs. A frame ends after FRAME_LEN samples or on an early `in_last`. At frame end the block presents one result beat on a valid/ready output, then starts a fresh frame. Signed or unsigned comparison is selected per frame.

## Interface
- WIDTH, 8, sample width in bits (≥2)
- FRAME_LEN, 16, maximum samples per frame (≥1)
- IDXW, $clog2(FRAME_LEN) (min 1), index width, derived
- CNTW, $clog2(FRAME_LEN+1), count width, derived

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample
- in_data  in  WIDTH  sample value
- in_last  in  1  final sample of frame (early terminate)
- is_signed  in  1  two's-complement compare; latched with first sample of frame
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- out_min  out  WIDTH  frame minimum (raw bits)
- out_max  out  WIDTH  frame maximum (raw bits)
- out_min_idx  out  IDXW  index of first occurrence of min
- out_max_idx  out  IDXW  index of first occurrence of max
- out_count  out  CNTW  samples in frame (1..FRAME_LEN)
- out_flat  out  1  out_min == out_max

## Operation
- Two states: ACCUM (reset state) and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - First accept of a frame (count==0): min=max=in_data; both idx=0; latch is_signed; count=1.
  - Later accepts update the running results:
    - if in_data < min (strict): min=in_data, min_idx=count.
    - if in_data > max (strict): max=in_data, max_idx=count.
    - count increments.
  - Ties keep the earliest index.
- Compare mode: the latched mode bit governs the whole frame. Signed compares the MSB-extended values; unsigned compares plain binary. is_signed changes mid-frame are ignored.
- Frame end: an accept with in_last=1, or an accept with count==FRAME_LEN-1, moves the block to HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - All out_* are stable until out_ready=1.
  - On the out_ready handshake the block returns to ACCUM and clears count to 0.
  - in_valid during HOLD is ignored; no sample is consumed.
- out_flat = (out_min==out_max), a combinational function of the registered results.
- Reset (any state, including mid-frame or mid-HOLD):
  - state=ACCUM, count=0.
  - out_valid=0, in_ready=0 while rst is high.
  - out_min, out_max, both idx and out_count are 0; out_flat is therefore 1.
  - Partial-frame data is discarded.

## Timing
- in_ready = (state==ACCUM) & ~rst. There is no combinational path from out_ready to in_ready.
- One sample per cycle in ACCUM; no bubbles between samples.
- Latency: out_valid rises on the clock edge that accepts the final sample, so it is visible the cycle after that accept.
- Result handshake takes ≥1 cycle in HOLD. in_ready returns the cycle after the out_ready handshake. Minimum frame period = count + 1 cycles.
- Result registers update only on accepts; values in HOLD are bit-stable.
- in_last together with count==FRAME_LEN-1 counts as a single frame end; there is no double termination.

## Test plan
Directed tests use WIDTH=4 and FRAME_LEN=4 unless stated.

- **Unsigned frame:** stream 3,9,1,9 with is_signed=0 and out_ready=1 → out_valid one cycle after 4th accept; min=1, min_idx=2, max=9, max_idx=1 (first occurrence), count=4, flat=0.
- **Mode select:** stream F,7,8,0.
  - is_signed=1 → min=8 (−8) idx2, max=7 idx1.
  - Same data, is_signed=0 → min=0 idx3, max=F idx0.
  - Toggling is_signed after the first sample changes nothing.
- **Early end:** 5, then 5 with in_last=1 → count=2, min=max=5, both idx=0, flat=1. Next frame starts with count=0.
- **Backpressure:** hold out_ready=0 for 3 cycles in HOLD while driving in_valid=1, data=2 → out_valid stays 1, outputs unchanged, in_ready=0, no sample absorbed. After the handshake, in_ready=1 on the next cycle.
- **Reset mid-frame:** after accepting 6,4, assert rst for 1 cycle → out_valid=0, all results 0, in_ready=0 during rst. Then stream 1,2,3,4 → min=1 idx0, max=4 idx3, count=4.
- **Single sample with full wrap:** FRAME_LEN=1, stream A → count=1, min=max=A, flat=1. Repeat back-to-back with out_ready=1 → one result every 2 cycles.
